// File: rtl/serial_deserializer_pkg.sv
// serial_pkg: shared FSM encoding, bit-order enum and counter sizing for the serial link blocks.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic {
        ORDER_MSB = 1'b0,
        ORDER_LSB = 1'b1
    } bit_order_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if: serial input and parallel valid/ready output of the deserializer.
//   start/sin/sin_valid : frame start and qualified serial bits toward the receiver
//   q/q_valid/q_ready   : assembled word handshake toward the consumer
//   master = transmitter/consumer side, slave = deserializer side
interface serial_deserializer_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;

    modport master (output start, sin, sin_valid, q_ready, input q, q_valid);
    modport slave  (input start, sin, sin_valid, q_ready, output q, q_valid);
endinterface

// File: rtl/serial_deserializer_bit_counter.sv
// bit_counter: counts received bits 0..WIDTH-1 and flags the last bit of a word.
//   clock, reset (async active-low), en (count), clr (sync clear, wins over en), tc (count is WIDTH-1)
module bit_counter
    import serial_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);
    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: collects WIDTH serial bits after a start and presents them as a buffered parallel word.
//   clock, reset (async active-low), e (global enable/freeze), clear_ovr (sync overrun clear)
//   bus (slave): start, sin, sin_valid in; q, q_valid out; q_ready in
//   busy: state is not IDLE; overrun: sticky, a qualified bit was dropped while a word was held
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  e,
    input  logic                  clear_ovr,
    serial_deserializer_if.slave  bus,
    output logic                  busy,
    output logic                  overrun
);
    localparam bit_order_e ORDER = LSB_FIRST ? ORDER_LSB : ORDER_MSB;

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] sh, sh_n, shifted, q_n;
    logic             q_valid_n, overrun_n;
    logic             in_idle, in_shift, in_hold;
    logic             drain, frame_start, bit_in, tc, done, load;

    assign in_idle     = (state == ST_IDLE);
    assign in_shift    = (state == ST_SHIFT);
    assign in_hold     = (state == ST_HOLD);
    assign busy        = !in_idle;
    assign drain       = bus.q_valid & bus.q_ready;
    assign frame_start = e & bus.start & (in_idle | in_shift);
    assign bit_in      = e & in_shift & !bus.start & bus.sin_valid;
    assign done        = bit_in & tc;
    // Completed word goes straight to q when the output slot is free or being vacated.
    assign load        = done & (!bus.q_valid | drain);
    assign shifted     = (ORDER == ORDER_LSB) ? {bus.sin, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], bus.sin};

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock (clock),
        .reset (reset),
        .en    (bit_in),
        .clr   (frame_start),
        .tc    (tc)
    );

    always_comb begin
        state_n   = (in_idle & bus.start) ? ST_SHIFT :
                    done                  ? (load ? ST_IDLE : ST_HOLD) :
                    (in_hold & drain)     ? ST_IDLE : state;
        sh_n      = frame_start ? '0 : bit_in ? shifted : sh;
        // In HOLD the waiting word sits in sh and moves to q when the consumer drains.
        q_n       = load ? shifted : (in_hold & drain) ? sh : bus.q;
        q_valid_n = load | (in_hold & drain) | (bus.q_valid & !drain);
        overrun_n = (in_hold & bus.sin_valid) | (overrun & !clear_ovr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sh          <= '0;
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (e) begin
            state       <= state_n;
            sh          <= sh_n;
            bus.q       <= q_n;
            bus.q_valid <= q_valid_n;
            overrun     <= overrun_n;
        end
    end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel receiver: the receiving end of the serial bit stream our multi-function shift registers emit when shifting right. It collects WIDTH qualified bits after a frame start and reassembles them into a parallel word. It presents the word on a valid/ready output port and buffers one complete word under backpressure. It sits between a shift-register transmitter and any parallel consumer (register file, ALU operand latch).

## Interface
Parameters:
- WIDTH, 8, word width in bits (≥2).
- LSB_FIRST, 1. 1: first received bit lands in q[0], matching right-shift emission. 0: first bit lands in q[WIDTH-1].

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- e  in  1  enable. 0 freezes FSM, counter, shift register and output handshake. q_ready is ignored while e=0.
- start  in  1  begin a new frame.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is qualified this cycle.
- q  out  WIDTH  assembled word, stable while q_valid=1.
- q_valid  out  1  q holds an undelivered word.
- q_ready  in  1  consumer accepts q this cycle.
- busy  out  1  frame in progress or word held (state ≠ IDLE).
- overrun  out  1  sticky; a qualified bit was dropped.
- clear_ovr  in  1  synchronous clear of overrun.

## Operation
- Internal state: shift register sh[WIDTH-1:0], bit counter cnt (0..WIDTH-1), FSM {IDLE, SHIFT, HOLD}.
- All transitions below require e=1. A cycle with e=0 changes nothing except asynchronous reset.
- Bit shift-in:
  - LSB_FIRST=1: sh ← {sin, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh ← {sh[WIDTH-2:0], sin}.
- Drain: a cycle with q_valid & q_ready.

IDLE
- sin and sin_valid are ignored.
- start → SHIFT, with cnt←0 and sh←0.

SHIFT
- start has priority over sin_valid: it discards the partial word and sets cnt←0, sh←0. The state stays SHIFT.
- sin_valid with cnt<WIDTH-1: shift in sin, cnt++.
- sin_valid with cnt=WIDTH-1 (word complete):
  - If q_valid=0 or a drain occurs this cycle: q ← shifted word, q_valid←1 → IDLE.
  - Otherwise: latch the shifted word in sh → HOLD.

HOLD
- Drain: q ← sh, q_valid stays 1 → IDLE.
- sin_valid: the bit is dropped and overrun←1.
- start is ignored.

Output handshake
- A drain with no new word loaded that edge clears q_valid.
- q never changes while q_valid=1 except at a drain edge.

Overrun
- Set by any dropped qualified bit.
- clear_ovr clears it.
- If set and clear occur together, set wins.

## Timing
- Reset (asynchronous assert, any time including mid-frame): state IDLE, cnt 0, sh 0, q 0, q_valid 0, busy 0, overrun 0.
- Latency: q and q_valid update on the same edge that samples the last bit. The minimum frame is 1 start cycle plus WIDTH bit cycles.
- Back-to-back throughput: start may be asserted the cycle after completion. A new word may load at a drain edge with no q_valid bubble.
- busy is registered and equals (state ≠ IDLE); it rises the edge after start is sampled.

## Structure
- Shared package `serial_pkg`:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2).
  - Counter width constant `$clog2(WIDTH)`.
  - Bit-order enum used by LSB_FIRST.
  - Reused by a future serial transmitter.
- One sub-module: `bit_counter` (enable, synchronous clear, terminal-count flag at WIDTH-1).
- FSM, shift register and output buffer stay in the top module.

## Test plan
- Reset mid-frame: after 3 bits, pulse reset low → all outputs 0 immediately. A following full frame yields the correct word.
- LSB_FIRST=1, WIDTH=8: start, then bits 0,1,0,1,0,1,0,1 with q_ready=1 → q=8'b1010_1010 and q_valid=1 on the 8th-bit edge, q_valid=0 the next edge.
- Gaps and freeze: same stream with sin_valid low on alternate cycles and e=0 for 3 cycles mid-frame → q=8'b1010_1010; no extra bits counted.
- Backpressure: q_ready=0, frames 8'hAA then 8'h3C → second frame enters HOLD with busy=1. One extra sin_valid sets overrun=1. Raising q_ready → q=8'h3C at that edge, q_valid stays 1. clear_ovr → overrun=0.
- Restart: start, 3 bits, start again, then 8'hC3 LSB-first → q=8'hC3.
- LSB_FIRST=0: bits 0,1,0,1,0,1,0,1 → q=8'b0101_0101.
